// File: rtl/motor_start_sequencer_pkg.sv
// Shared state encoding and width helper for the motor start sequencer
// and its qualification core.
package motor_seq_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SELECT = 4'd1,
    PULSE  = 4'd2,
    S0     = 4'd3,
    S1     = 4'd4,
    S10    = 4'd5,
    G1     = 4'd6,
    G2     = 4'd7,
    PASS   = 4'd8,
    RETRY  = 4'd9,
    DONE   = 4'd10
  } seq_state_t;

  function automatic int chSelWidth(input int nCh);
    return (nCh < 2) ? 1 : $clog2(nCh);
  endfunction

endpackage

// File: rtl/motor_start_sequencer_if.sv
// Bundles the run-control handshake and the shared motor sensor lines.
// The master side is the run controller together with the selected motor.
interface motor_start_sequencer_if #(
  parameter int N_CH = 4
);
  import motor_seq_pkg::*;

  localparam int CW = chSelWidth(N_CH);

  logic            start;
  logic [N_CH-1:0] chEnable;
  logic            x;
  logic            y;
  logic            f;
  logic            g;
  logic [CW-1:0]   chSel;
  logic            busy;
  logic            done;
  logic [N_CH-1:0] passMask;
  logic [N_CH-1:0] failMask;

  modport master (
    output start, chEnable, x, y,
    input  f, g, chSel, busy, done, passMask, failMask
  );

  modport slave (
    input  start, chEnable, x, y,
    output f, g, chSel, busy, done, passMask, failMask
  );

endinterface

// File: rtl/motor_start_sequencer_qual.sv
// Single-attempt qualification: start pulse, bounded 1,0,1 detection on x,
// then a two-cycle y-check with g asserted. Reports one-cycle pass or fail.
module motor_qual_core
  import motor_seq_pkg::*;
#(
  parameter int X_TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_go,
  input  logic i_x,
  input  logic i_y,
  output logic o_f,
  output logic o_g,
  output logic o_qualPass,
  output logic o_qualFail
);

  localparam int TW = $clog2(X_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(X_TIMEOUT - 1);

  seq_state_t    r_state;
  logic [TW-1:0] r_timer;
  seq_state_t    w_detNext;
  logic          w_detecting;
  logic          w_timeout;

  // Overlapping detector: a trailing 1 after the 0 may start the next pattern
  always_comb begin
    w_detNext = r_state;
    case (r_state)
      S0:      w_detNext = i_x ? S1 : S0;
      S1:      w_detNext = i_x ? S1 : S10;
      S10:     w_detNext = i_x ? G1 : S0;
      default: w_detNext = r_state;
    endcase
  end

  assign w_detecting = (r_state == S0) || (r_state == S1) || (r_state == S10);
  assign w_timeout   = w_detecting && (r_timer == TIMER_LAST) && (w_detNext != G1);

  assign o_f        = (r_state == PULSE);
  assign o_g        = (r_state == G1) || (r_state == G2);
  assign o_qualPass = o_g && i_y;
  assign o_qualFail = w_timeout || ((r_state == G2) && !i_y);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE:  if (i_go) r_state <= PULSE;
        PULSE: begin
          r_timer <= '0;
          r_state <= S0;
        end
        S0, S1, S10: begin
          if (w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_state <= w_detNext;
            r_timer <= r_timer + 1'b1;
          end
        end
        G1:      r_state <= i_y ? IDLE : G2;
        G2:      r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motor_start_sequencer.sv
// Walks the enabled motor channels one at a time, running the qualification
// core per attempt with retries, and records per-channel pass/fail.
module motor_start_sequencer
  import motor_seq_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int X_TIMEOUT = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  motor_start_sequencer_if.slave  io_bus
);

  localparam int CW = chSelWidth(N_CH);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(N_CH - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  seq_state_t      r_state;
  logic [CW-1:0]   r_ch;
  logic [N_CH-1:0] r_enQ;
  logic [RW-1:0]   r_retryCnt;
  logic [N_CH-1:0] r_passMask;
  logic [N_CH-1:0] r_failMask;

  logic w_go;
  logic w_lastCh;
  logic w_qualPass;
  logic w_qualFail;

  assign w_lastCh = (r_ch == CH_LAST);
  assign w_go     = ((r_state == SELECT) && r_enQ[r_ch]) ||
                    ((r_state == RETRY) && (r_retryCnt != RETRY_LAST));

  motor_qual_core #(
    .X_TIMEOUT (X_TIMEOUT)
  ) u_qual (
    .clk        (clk),
    .resetn     (resetn),
    .i_go       (w_go),
    .i_x        (io_bus.x),
    .i_y        (io_bus.y),
    .o_f        (io_bus.f),
    .o_g        (io_bus.g),
    .o_qualPass (w_qualPass),
    .o_qualFail (w_qualFail)
  );

  // PULSE here stands for the whole PULSE..G2 span that the core sequences
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_enQ      <= '0;
      r_retryCnt <= '0;
      r_passMask <= '0;
      r_failMask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_enQ      <= io_bus.chEnable;
            r_passMask <= '0;
            r_failMask <= '0;
            r_ch       <= '0;
            r_state    <= (io_bus.chEnable == '0) ? DONE : SELECT;
          end
        end
        SELECT: begin
          if (r_enQ[r_ch]) begin
            r_retryCnt <= '0;
            r_state    <= PULSE;
          end else if (w_lastCh) begin
            r_state <= DONE;
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        PULSE: begin
          if (w_qualPass)      r_state <= PASS;
          else if (w_qualFail) r_state <= RETRY;
        end
        PASS: begin
          r_passMask[r_ch] <= 1'b1;
          if (w_lastCh) begin
            r_state <= DONE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= SELECT;
          end
        end
        RETRY: begin
          if (r_retryCnt == RETRY_LAST) begin
            r_failMask[r_ch] <= 1'b1;
            if (w_lastCh) begin
              r_state <= DONE;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_state <= SELECT;
            end
          end else begin
            r_retryCnt <= r_retryCnt + 1'b1;
            r_state    <= PULSE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.chSel    = r_ch;
  assign io_bus.busy     = (r_state != IDLE);
  assign io_bus.done     = (r_state == DONE);
  assign io_bus.passMask = r_passMask;
  assign io_bus.failMask = r_failMask;

endmodule

// File: tb/tb_motor_start_sequencer.sv
// Directed bench: four modelled motors muxed by chSel, each with a scripted
// x/y response, and hand-computed latencies and masks per run.
module tb_motor_start_sequencer;

  localparam int N_CH = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  motor_start_sequencer_if #(.N_CH(N_CH)) seqIf ();

  motor_start_sequencer #(
    .N_CH      (N_CH),
    .X_TIMEOUT (16),
    .MAX_RETRY (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .io_bus (seqIf)
  );

  int checkCount = 0;
  int errorCount = 0;
  int cyc        = 0;
  int k          = 1000;
  int doneSeen   = 0;
  int doneCyc    = -1;
  int fLog[$];
  int fChLog[$];
  int motorMode[N_CH];
  int fBase;
  int doneBase;

  // Motor modes: 0 fast pass, 1 x stuck low, 2 y only in G2,
  // 3 y one cycle after G2, 4 pattern completes on the last detection cycle
  function automatic logic motorX(input int mode, input int kk);
    case (mode)
      1:       return 1'b0;
      4:       return (kk == 13) || (kk == 15);
      default: return (kk == 0) || (kk == 2);
    endcase
  endfunction

  function automatic logic motorY(input int mode, input int kk);
    case (mode)
      1:       return 1'b0;
      2:       return kk == 4;
      3:       return kk == 5;
      4:       return kk == 16;
      default: return kk == 3;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // k counts detection cycles from the first S0 of the current attempt
  always @(negedge clk) begin
    if (seqIf.f) begin
      fLog.push_back(cyc);
      fChLog.push_back(int'(seqIf.chSel));
      k = -1;
    end else if (k < 1000) begin
      k = k + 1;
    end
    if (seqIf.done) begin
      doneSeen = doneSeen + 1;
      doneCyc  = cyc;
    end
    seqIf.x = motorX(motorMode[seqIf.chSel], k);
    seqIf.y = motorY(motorMode[seqIf.chSel], k);
  end

  function automatic int fPulses(input int ch);
    int n = 0;
    for (int i = fBase; i < fChLog.size(); i++)
      if (fChLog[i] == ch) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] enable, output int startCyc);
    fBase            = fLog.size();
    doneBase         = doneSeen;
    seqIf.chEnable   = enable;
    seqIf.start      = 1'b1;
    startCyc         = cyc;
    tick();
    seqIf.start      = 1'b0;
    seqIf.chEnable   = '0;
  endtask

  task automatic waitDone(input string tag, input int startCyc, output int latency);
    int budget = 400;
    while (doneSeen == doneBase && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput({tag, "_donePulses"}, doneSeen - doneBase, 1);
    latency = (doneSeen > doneBase) ? (doneCyc - startCyc) : -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int lat;
    logic found;

    resetn         = 1'b0;
    seqIf.start    = 1'b0;
    seqIf.chEnable = '0;
    for (int i = 0; i < N_CH; i++) motorMode[i] = 0;
    fBase    = 0;
    doneBase = 0;
    repeat (3) tick();

    checkOutput("rst_busy", seqIf.busy, 0);
    checkOutput("rst_done", seqIf.done, 0);
    checkOutput("rst_f", seqIf.f, 0);
    checkOutput("rst_g", seqIf.g, 0);
    checkOutput("rst_chSel", seqIf.chSel, 0);
    checkOutput("rst_passMask", seqIf.passMask, 0);
    checkOutput("rst_failMask", seqIf.failMask, 0);
    resetn = 1'b1;
    tick();

    $display("[TB] all channels pass");
    applyStimulus(4'b1111, t0);
    checkOutput("allPass_busy", seqIf.busy, 1);
    waitDone("allPass", t0, lat);
    checkOutput("allPass_latency", lat, 29);
    checkOutput("allPass_passMask", seqIf.passMask, 15);
    checkOutput("allPass_failMask", seqIf.failMask, 0);
    checkOutput("allPass_fTotal", fLog.size() - fBase, 4);
    for (int i = 0; i < N_CH; i++)
      checkOutput($sformatf("allPass_fCh%0d", i), fPulses(i), 1);
    checkOutput("allPass_busyAfter", seqIf.busy, 0);

    $display("[TB] skipped channels");
    applyStimulus(4'b0101, t0);
    waitDone("skip", t0, lat);
    checkOutput("skip_latency", lat, 17);
    checkOutput("skip_passMask", seqIf.passMask, 5);
    checkOutput("skip_failMask", seqIf.failMask, 0);
    for (int i = 0; i < N_CH; i++)
      checkOutput($sformatf("skip_fCh%0d", i), fPulses(i), (i % 2 == 0) ? 1 : 0);

    $display("[TB] x timeout with retries");
    motorMode[1] = 1;
    applyStimulus(4'b0010, t0);
    waitDone("timeout", t0, lat);
    checkOutput("timeout_latency", lat, 59);
    checkOutput("timeout_fCh1", fPulses(1), 3);
    checkOutput("timeout_fSpan", (fLog.size() - fBase == 3) ? (fLog[fLog.size()-1] - fLog[fBase]) : -1, 36);
    checkOutput("timeout_failMask", seqIf.failMask, 2);
    checkOutput("timeout_passMask", seqIf.passMask, 0);

    $display("[TB] y window boundaries");
    motorMode[0] = 2;
    motorMode[1] = 3;
    motorMode[2] = 4;
    motorMode[3] = 0;
    applyStimulus(4'b1111, t0);
    waitDone("yWin", t0, lat);
    checkOutput("yWin_latency", lat, 58);
    checkOutput("yWin_passMask", seqIf.passMask, 13);
    checkOutput("yWin_failMask", seqIf.failMask, 2);
    checkOutput("yWin_fCh0", fPulses(0), 1);
    checkOutput("yWin_fCh1", fPulses(1), 3);
    checkOutput("yWin_fCh2", fPulses(2), 1);
    checkOutput("yWin_fCh3", fPulses(3), 1);

    $display("[TB] edge commands");
    for (int i = 0; i < N_CH; i++) motorMode[i] = 0;
    applyStimulus(4'b0000, t0);
    waitDone("empty", t0, lat);
    checkOutput("empty_latency", lat, 1);
    checkOutput("empty_passMask", seqIf.passMask, 0);
    checkOutput("empty_failMask", seqIf.failMask, 0);
    checkOutput("empty_fTotal", fLog.size() - fBase, 0);

    applyStimulus(4'b0001, t0);
    repeat (2) tick();
    seqIf.start    = 1'b1;
    seqIf.chEnable = 4'b1111;
    repeat (2) tick();
    seqIf.start    = 1'b0;
    seqIf.chEnable = '0;
    waitDone("busyStart", t0, lat);
    checkOutput("busyStart_latency", lat, 11);
    checkOutput("busyStart_passMask", seqIf.passMask, 1);
    checkOutput("busyStart_fTotal", fLog.size() - fBase, 1);

    applyStimulus(4'b0001, t0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (seqIf.done) found = 1'b1;
      else tick();
    end
    checkOutput("doneStart_reached", found, 1);
    seqIf.start    = 1'b1;
    seqIf.chEnable = 4'b1110;
    tick();
    seqIf.start    = 1'b0;
    seqIf.chEnable = '0;
    checkOutput("doneStart_busy", seqIf.busy, 0);
    tick();
    checkOutput("doneStart_busyLater", seqIf.busy, 0);
    checkOutput("doneStart_passMask", seqIf.passMask, 1);

    $display("[TB] reset during G1");
    applyStimulus(4'b1111, t0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (seqIf.g && seqIf.chSel == 1) found = 1'b1;
    end
    checkOutput("midRst_reachedG1", found, 1);
    checkOutput("midRst_prePassMask", seqIf.passMask, 1);
    resetn = 1'b0;
    tick();
    checkOutput("midRst_g", seqIf.g, 0);
    checkOutput("midRst_busy", seqIf.busy, 0);
    checkOutput("midRst_chSel", seqIf.chSel, 0);
    checkOutput("midRst_passMask", seqIf.passMask, 0);
    checkOutput("midRst_failMask", seqIf.failMask, 0);
    resetn = 1'b1;
    tick();
    applyStimulus(4'b1111, t0);
    waitDone("afterRst", t0, lat);
    checkOutput("afterRst_latency", lat, 29);
    checkOutput("afterRst_passMask", seqIf.passMask, 15);
    checkOutput("afterRst_failMask", seqIf.failMask, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/motor_start_sequencer.md
# motor_start_sequencer

Controller that brings up `N_CH` motor channels one at a time through a single shared sensor path. For each enabled channel it:

- issues a one-cycle start pulse `f`,
- qualifies the `x` feedback for the pattern 1,0,1 within a timeout,
- asserts `g` and checks `y` within two cycles,
- retries up to `MAX_RETRY` times, then records pass or fail.

It sits above the per-motor drive logic; `ch_sel` steers the shared `f`/`g`/`x`/`y` lines to the selected motor.

## Interface
Parameters:
- `N_CH`, default 4: number of motor channels, ≥2.
- `X_TIMEOUT`, default 16: maximum cycles spent in x-pattern detection per attempt, ≥4.
- `MAX_RETRY`, default 2: retries after the first failed attempt. Total attempts per channel = `MAX_RETRY`+1.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `start` in 1: begin a sequencing run. Ignored while `busy`=1.
- `ch_enable` in `N_CH`: channels to sequence. Sampled on the accepted `start`.
- `x` in 1: feedback from the selected motor.
- `y` in 1: confirmation from the selected motor.
- `f` out 1: one-cycle start pulse to the selected motor.
- `g` out 1: enable to the selected motor during the y-check.
- `ch_sel` out `$clog2(N_CH)`: currently selected channel.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass_mask` out `N_CH`: bit set when the channel passes. Held until the next accepted `start`.
- `fail_mask` out `N_CH`: bit set when the channel exhausts its retries. Held likewise.

## Operation
- **State set:** IDLE, SELECT, PULSE, S0, S1, S10, G1, G2, PASS, RETRY, DONE. Registers: `ch`, `en_q`, `timer`, `retry_cnt`.
- **IDLE** (`busy`=0)
  - `start`=1 latches `ch_enable` into `en_q`, clears both masks and sets `ch`=0.
  - Goes to SELECT, or straight to DONE if `ch_enable`=0.
- **SELECT**
  - If `en_q[ch]`=1: clear `retry_cnt` and go to PULSE.
  - Otherwise advance: if `ch`=`N_CH`-1 go to DONE, else `ch`++ and stay in SELECT.
  - One cycle per skipped channel.
- **PULSE:** `f`=1, `timer`=0, then S0.
- **S0 / S1 / S10:** overlapping 1,0,1 detector.
  - S0: `x`=1 → S1, else S0.
  - S1: `x`=0 → S10, else S1.
  - S10: `x`=1 → G1, else S0.
  - Each detection cycle: if `timer`=`X_TIMEOUT`-1 and the next state is not G1, go to RETRY. Otherwise `timer`++.
  - The transition to G1 takes priority over the timeout.
- **G1** (`g`=1): `y`=1 → PASS, else G2.
- **G2** (`g`=1): `y`=1 → PASS, else RETRY.
- **PASS:** set `pass_mask[ch]`, then advance as in SELECT.
- **RETRY**
  - If `retry_cnt`=`MAX_RETRY`: set `fail_mask[ch]` and advance.
  - Otherwise `retry_cnt`++ and go to PULSE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Output rules**
  - `f`=1 only in PULSE; `g`=1 only in G1 and G2. Both are decoded from state, with no extra register stage.
  - `ch_sel`=`ch` at all times.
  - A channel never has both mask bits set.
- **Reset values** (on `resetn`=0 at any point, including mid-run): state IDLE; `f`, `g`, `busy`, `done` = 0; `ch_sel` = 0; both masks = 0. `ch_enable` and `start` are ignored during reset.
- Illegal state encodings go to IDLE.

## Timing
- Accepted `start` at cycle t: SELECT at t+1. If channel 0 is enabled, `f`=1 at t+2.
- **Fastest pass:** PULSE t+2, S0 t+3 (`x`=1), S1 t+4 (`x`=0), S10 t+5 (`x`=1), G1 t+6 (`y`=1), PASS t+7, SELECT for the next channel at t+8.
- **Detection window:** at most `X_TIMEOUT` cycles per attempt, counted from the first S0 cycle.
- **y-check window:** `y` is sampled only in G1 and G2, i.e. the two cycles after leaving S10.
- **Fail path:** a failing attempt re-enters PULSE the cycle after RETRY, so `f` pulses once per attempt.
- **Run end:** `busy` falls the cycle after `done`. A `start` asserted during the `done` cycle is ignored.

## Structure
- Package `motor_seq_pkg`: state enum `seq_state_t` and localparam helpers for `$clog2(N_CH)` width.
- One natural sub-module, `motor_qual_core`:
  - covers states PULSE..G2 plus `timer`;
  - inputs: `go`, `x`, `y`;
  - outputs: `f`, `g`, and one-cycle `qual_pass` / `qual_fail`.
- The top level keeps SELECT/PASS/RETRY/DONE, `ch`, `retry_cnt` and the masks.

## Test plan
- **All pass:** `N_CH`=4, `ch_enable`=4'b1111, each channel x=1,0,1 then y=1 in G1 → `pass_mask`=4'b1111, `fail_mask`=0, `f` pulses exactly 4 times, `done` at t+29.
- **Skip:** `ch_enable`=4'b0101 → `f` pulses only with `ch_sel`=0 and `ch_sel`=2. One SELECT cycle per skipped channel.
- **Timeout with retries:** `x` held 0 on ch1 → 3 `f` pulses on ch1, each attempt exactly 16 detection cycles, then `fail_mask[1]`=1.
- **y boundary:** `y`=1 only in G2 → pass. `y`=1 only one cycle after G2 → retry. Detection landing in G1 on the `timer`=15 cycle → pass, not retry.
- **Edge commands:** `start` with `ch_enable`=0 → `done` at t+1, masks 0. `start` while `busy` → ignored.
- **Mid-run reset:** `resetn`=0 in G1 → next cycle IDLE, `g`=0, masks 0. A new `start` then runs normally.
